emif_buffer_loader: RTL and testbench

// - Read-side initiator for the external memory interface (EMIF). Streams a

---
 rtl/emif_buffer_loader.sv | 240 ++++++++++++++++++++++++
 tb/tb_emif_buffer_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/emif_buffer_loader.sv
// emif_buffer_loader: read-side EMIF initiator that copies a contiguous range of
// EMIF words into an ML block buffer port. It issues one read per cycle and
// drains the reads through a READ_LAT-deep valid pipe into registered buffer
// writes.
//
// Optional feature macro: EMIF_BUFFER_LOADER_CHECKSUM_EN
//   defined   -> checksum_o XOR-accumulates every word written to the buffer
//   undefined -> checksum_o is tied to zero and no accumulator is built
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | out of reset, waiting for start
// ISSUE | one EMIF read address per cycle, length cycles in total
// DRAIN | no new reads; waiting for the last buffer write to go out
// DONE  | done high, error valid; a new start is accepted here

module emif_buffer_loader #(
    parameter int EMIF_ADDR_WIDTH = 12,
    parameter int BUF_ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH      = 128,
    parameter int READ_LAT        = 1
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       start_i,
    input  logic [EMIF_ADDR_WIDTH-1:0] src_base_i,
    input  logic [BUF_ADDR_WIDTH-1:0]  dst_base_i,
    input  logic [BUF_ADDR_WIDTH:0]    length_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       error_o,
    output logic [EMIF_ADDR_WIDTH-1:0] emif_address_o,
    output logic                       emif_wen_o,
    output logic [DATA_WIDTH-1:0]      emif_datain_o,
    input  logic [DATA_WIDTH-1:0]      emif_dataout_i,
    output logic [BUF_ADDR_WIDTH-1:0]  buf_addr_o,
    output logic [DATA_WIDTH-1:0]      buf_datain_o,
    output logic                       buf_wen_o,
    output logic [DATA_WIDTH-1:0]      checksum_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam int LEN_W = BUF_ADDR_WIDTH + 1;
    // One extra bit so dst_base + length can exceed the buffer depth without wrapping.
    localparam int SUM_W = BUF_ADDR_WIDTH + 2;
    localparam logic [SUM_W-1:0] BUF_DEPTH = SUM_W'(1) << BUF_ADDR_WIDTH;

    state_e state_q, state_d;

    logic                       start_acc;
    logic                       len_zero;
    logic                       out_of_range;
    logic                       go_issue;
    logic                       issue_vld;
    logic                       issue_last;
    logic                       cap_vld;
    logic                       drain_last;
    logic [SUM_W-1:0]           dst_end;

    logic [LEN_W-1:0]           iss_left_q;
    logic [LEN_W-1:0]           cap_left_q;
    logic [EMIF_ADDR_WIDTH-1:0] addr_q;
    logic [BUF_ADDR_WIDTH-1:0]  dst_ptr_q;
    logic                       error_q;
    logic                       buf_wen_q;
    logic [BUF_ADDR_WIDTH-1:0]  buf_addr_q;
    logic [DATA_WIDTH-1:0]      buf_data_q;

    // start is only honoured when no transfer is in flight.
    assign start_acc    = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign len_zero     = (length_i == '0);
    assign dst_end      = SUM_W'(dst_base_i) + SUM_W'(length_i);
    assign out_of_range = (dst_end > BUF_DEPTH);
    assign go_issue     = start_acc && !len_zero && !out_of_range;

    assign issue_vld    = (state_q == S_ISSUE);
    assign issue_last   = issue_vld && (iss_left_q == LEN_W'(1));
    // All captures have happened once cap_left reaches zero, so a write
    // pending in that state is the final one.
    assign drain_last   = buf_wen_q && (cap_left_q == '0);

    // State register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_acc) begin
                    state_d = go_issue ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                if (issue_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_last) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            S_ISSUE, S_DRAIN: busy_o = 1'b1;
            S_DONE:           done_o = 1'b1;
            default: begin
                busy_o = 1'b0;
                done_o = 1'b0;
            end
        endcase
    end

    // Issue/capture down-counters, EMIF read address and buffer write pointer.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            iss_left_q <= '0;
            cap_left_q <= '0;
            addr_q     <= '0;
            dst_ptr_q  <= '0;
            error_q    <= 1'b0;
        end else begin
            if (start_acc) begin
                error_q <= out_of_range;
            end
            // Rejected and empty requests leave the EMIF address untouched.
            if (go_issue) begin
                iss_left_q <= length_i;
                cap_left_q <= length_i;
                addr_q     <= src_base_i;
                dst_ptr_q  <= dst_base_i;
            end else begin
                if (issue_vld) begin
                    iss_left_q <= iss_left_q - LEN_W'(1);
                    // The last issued address is held through DRAIN.
                    if (!issue_last) begin
                        addr_q <= addr_q + EMIF_ADDR_WIDTH'(1);
                    end
                end
                if (cap_vld) begin
                    cap_left_q <= cap_left_q - LEN_W'(1);
                    dst_ptr_q  <= dst_ptr_q + BUF_ADDR_WIDTH'(1);
                end
            end
        end
    end

    // Valid pipe matching the responder latency; its output marks the
    // cycle in which emif_dataout_i carries a requested word.
    generate
        if (READ_LAT == 0) begin : g_lat0
            assign cap_vld = issue_vld;
        end else if (READ_LAT == 1) begin : g_lat1
            logic vld_q;
            // Single-stage valid delay.
            always_ff @(posedge clk_i or negedge reset_ni) begin
                if (!reset_ni) begin
                    vld_q <= 1'b0;
                end else begin
                    vld_q <= issue_vld;
                end
            end
            assign cap_vld = vld_q;
        end else begin : g_latn
            logic [READ_LAT-1:0] vld_q;
            // Multi-stage valid shift register.
            always_ff @(posedge clk_i or negedge reset_ni) begin
                if (!reset_ni) begin
                    vld_q <= '0;
                end else begin
                    vld_q <= {vld_q[READ_LAT-2:0], issue_vld};
                end
            end
            assign cap_vld = vld_q[READ_LAT-1];
        end
    endgenerate

    // Capture returning read data into the registered buffer write port.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            buf_wen_q  <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
        end else begin
            buf_wen_q <= cap_vld;
            if (cap_vld) begin
                buf_addr_q <= dst_ptr_q;
                buf_data_q <= emif_dataout_i;
            end
        end
    end

`ifdef EMIF_BUFFER_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] cksum_q;

    // XOR of every word presented on the buffer write port since the last start.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cksum_q <= '0;
        end else if (start_acc) begin
            cksum_q <= '0;
        end else if (buf_wen_q) begin
            cksum_q <= cksum_q ^ buf_data_q;
        end
    end

    assign checksum_o = cksum_q;
`else
    assign checksum_o = '0;
`endif

    assign error_o        = error_q;
    assign emif_address_o = addr_q;
    assign emif_wen_o     = 1'b0;
    assign emif_datain_o  = '0;
    assign buf_wen_o      = buf_wen_q;
    assign buf_addr_o     = buf_addr_q;
    assign buf_datain_o   = buf_data_q;

endmodule

// File: tb/tb_emif_buffer_loader.sv
// Testbench for emif_buffer_loader: one instance with a registered responder
// (READ_LAT=1) and one with a combinational responder (READ_LAT=0) driven by
// the same stimulus. Expected buffer writes are queued per instance when a
// transfer is launched and popped by negedge monitors.

module tb_emif_buffer_loader;

    typedef struct packed {
        logic [7:0]   a;
        logic [127:0] d;
    } wr_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [11:0]  src_base;
    logic [7:0]   dst_base;
    logic [8:0]   length;

    logic         busy1, done1, err1, ewen1, bwen1;
    logic [11:0]  addr1;
    logic [127:0] edin1, dout1, bdat1, cks1;
    logic [7:0]   baddr1;

    logic         busy0, done0, err0, ewen0, bwen0;
    logic [11:0]  addr0;
    logic [127:0] edin0, dout0, bdat0, cks0;
    logic [7:0]   baddr0;

    logic [127:0] mem [0:4095];
    wr_t          q1[$];
    wr_t          q0[$];

    int           n_chk;
    int           n_fail;

    emif_buffer_loader #(.READ_LAT(1)) u_dut1 (
        .clk_i(clk), .reset_ni(rst_n), .start_i(start),
        .src_base_i(src_base), .dst_base_i(dst_base), .length_i(length),
        .busy_o(busy1), .done_o(done1), .error_o(err1),
        .emif_address_o(addr1), .emif_wen_o(ewen1), .emif_datain_o(edin1),
        .emif_dataout_i(dout1),
        .buf_addr_o(baddr1), .buf_datain_o(bdat1), .buf_wen_o(bwen1),
        .checksum_o(cks1)
    );

    emif_buffer_loader #(.READ_LAT(0)) u_dut0 (
        .clk_i(clk), .reset_ni(rst_n), .start_i(start),
        .src_base_i(src_base), .dst_base_i(dst_base), .length_i(length),
        .busy_o(busy0), .done_o(done0), .error_o(err0),
        .emif_address_o(addr0), .emif_wen_o(ewen0), .emif_datain_o(edin0),
        .emif_dataout_i(dout0),
        .buf_addr_o(baddr0), .buf_datain_o(bdat0), .buf_wen_o(bwen0),
        .checksum_o(cks0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responders: one registered, one combinational.
    always @(posedge clk) dout1 <= mem[addr1];
    always_comb dout0 = mem[addr0];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Write monitors.
    always @(negedge clk) begin
        if (rst_n && bwen1) begin
            if (q1.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL lat1 unexpected write: got addr %0h data %0h expected no write", baddr1, bdat1);
            end else begin
                wr_t e;
                e = q1.pop_front();
                chk("lat1 buf_addr", 128'(baddr1), 128'(e.a));
                chk("lat1 buf_data", bdat1, e.d);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bwen0) begin
            if (q0.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL lat0 unexpected write: got addr %0h data %0h expected no write", baddr0, bdat0);
            end else begin
                wr_t e;
                e = q0.pop_front();
                chk("lat0 buf_addr", 128'(baddr0), 128'(e.a));
                chk("lat0 buf_data", bdat0, e.d);
            end
        end
    end

    task automatic run_xfer(input logic [11:0] src, input logic [7:0] dst, input logic [8:0] len,
                            input bit exp_err, input bit poke, input string tag);
        int          n, t1, t0, exp_t1, exp_t0;
        logic [11:0] a1_before, a0_before;
        bit          no_xfer;
        no_xfer = exp_err || (len == 9'd0);
        @(negedge clk);
        src_base  = src;
        dst_base  = dst;
        length    = len;
        start     = 1'b1;
        a1_before = addr1;
        a0_before = addr0;
        if (!no_xfer) begin
            for (int k = 0; k < int'(len); k++) begin
                wr_t e;
                e.a = dst + 8'(k);
                e.d = mem[src + 12'(k)];
                q1.push_back(e);
                q0.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        chk({tag, " busy lat1"}, 128'(busy1), 128'(!no_xfer));
        chk({tag, " busy lat0"}, 128'(busy0), 128'(!no_xfer));
        t1 = done1 ? 1 : 0;
        t0 = done0 ? 1 : 0;
        while (n < 300 && (t1 == 0 || t0 == 0)) begin
            if (poke && n == 2) begin
                start    = 1'b1;
                src_base = 12'h555;
                dst_base = 8'h00;
                length   = 9'd9;
            end
            @(posedge clk);
            #1;
            n++;
            if (poke && n == 3) start = 1'b0;
            if (done1 && t1 == 0) t1 = n;
            if (done0 && t0 == 0) t0 = n;
        end
        exp_t1 = no_xfer ? 1 : int'(len) + 3;
        exp_t0 = no_xfer ? 1 : int'(len) + 2;
        chk({tag, " cycles to done lat1"}, 128'(t1), 128'(exp_t1));
        chk({tag, " cycles to done lat0"}, 128'(t0), 128'(exp_t0));
        chk({tag, " error lat1"}, 128'(err1), 128'(exp_err));
        chk({tag, " error lat0"}, 128'(err0), 128'(exp_err));
        if (no_xfer) begin
            chk({tag, " emif_address held lat1"}, 128'(addr1), 128'(a1_before));
            chk({tag, " emif_address held lat0"}, 128'(addr0), 128'(a0_before));
        end
        repeat (2) @(posedge clk);
        #1;
        chk({tag, " done level lat1"}, 128'(done1), 128'(1));
        chk({tag, " done level lat0"}, 128'(done0), 128'(1));
        chk({tag, " pending writes lat1"}, 128'(q1.size()), 128'(0));
        chk({tag, " pending writes lat0"}, 128'(q0.size()), 128'(0));
    endtask

    initial begin
        logic [127:0] exp_cks;
        n_chk    = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        src_base = '0;
        dst_base = '0;
        length   = '0;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = {32'hDEAD_0000 | 32'(i), 32'(i * 3), ~32'(i), 32'h1234_0000 | 32'(i)};
        end
        mem[12'h010] = {16{8'hA0}};
        mem[12'h011] = {16{8'hA1}};
        mem[12'h012] = {16{8'hA2}};
        mem[12'h013] = {16{8'hA3}};
        mem[12'h100] = 128'h1;
        mem[12'h101] = 128'h2;
        mem[12'h102] = 128'h4;

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 128'({busy1, busy0}), 128'(0));
        chk("reset done", 128'({done1, done0}), 128'(0));
        chk("reset error", 128'({err1, err0}), 128'(0));
        chk("reset emif_address", 128'({addr1, addr0}), 128'(0));
        chk("reset buf_wen", 128'({bwen1, bwen0}), 128'(0));
        chk("reset buf_addr", 128'({baddr1, baddr0}), 128'(0));
        chk("reset buf_datain", bdat1 | bdat0, 128'(0));
        chk("reset checksum", cks1 | cks0, 128'(0));
        chk("emif_wen tied", 128'({ewen1, ewen0}), 128'(0));
        chk("emif_datain tied", edin1 | edin0, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_xfer(12'h010, 8'h04, 9'd4, 1'b0, 1'b0, "basic");
        run_xfer(12'h020, 8'h10, 9'd0, 1'b0, 1'b0, "zero_len");
        run_xfer(12'h030, 8'hFE, 9'd4, 1'b1, 1'b0, "bounds");
        run_xfer(12'h040, 8'hFC, 9'd4, 1'b0, 1'b0, "fits_top");
        run_xfer(12'hFFE, 8'h80, 9'd4, 1'b0, 1'b0, "wrap");

        run_xfer(12'h100, 8'h20, 9'd3, 1'b0, 1'b0, "cksum");
`ifdef EMIF_BUFFER_LOADER_CHECKSUM_EN
        exp_cks = 128'h7;
`else
        exp_cks = 128'h0;
`endif
        chk("cksum value lat1", cks1, exp_cks);
        chk("cksum value lat0", cks0, exp_cks);

        // Reset in the middle of an 8-word transfer, right after its 2nd write (lat1 timing).
        @(negedge clk);
        src_base = 12'h200;
        dst_base = 8'h10;
        length   = 9'd8;
        start    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wr_t e;
            e.a = 8'h10 + 8'(k);
            e.d = mem[12'h200 + 12'(k)];
            q1.push_back(e);
            q0.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midreset writes seen lat1", 128'(q1.size()), 128'(6));
        chk("midreset writes seen lat0", 128'(q0.size()), 128'(5));
        rst_n = 1'b0;
        #1;
        chk("midreset busy", 128'({busy1, busy0}), 128'(0));
        chk("midreset done", 128'({done1, done0}), 128'(0));
        chk("midreset buf_wen", 128'({bwen1, bwen0}), 128'(0));
        q1.delete();
        q0.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post reset buf_wen", 128'({bwen1, bwen0}), 128'(0));
        run_xfer(12'h300, 8'h30, 9'd2, 1'b0, 1'b1, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
